change_return_timer: RTL

- Parametrised successor to the vending machine's time/coin checker.
- Tracks the inactivity timeout and a configurable return delay after the user's return trigger.
- On timeout or delay expiry, dispenses change greedily, one coin per cycle, under a ready/valid handshake with the coin dispenser.
- Reports each debit to the total register upstream; sits between the input/total logic and the dispenser.

---
 rtl/change_return_timer_if.sv | 22 ++
 rtl/change_return_timer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/change_return_timer_if.sv
// Dispenser handshake bundle for change_return_timer.
// Ports: o_return_coin (one-hot or multi-hot coin), o_return_valid, i_disp_ready.
// The master is the change_return_timer. The slave is the coin dispenser.
interface change_return_timer_if #(
  parameter int NUM_COINS = 3
);
  logic [NUM_COINS-1:0] o_return_coin;
  logic                 o_return_valid;
  logic                 i_disp_ready;

  modport master (
    output o_return_coin,
    output o_return_valid,
    input  i_disp_ready
  );

  modport slave (
    input  o_return_coin,
    input  o_return_valid,
    output i_disp_ready
  );
endinterface

// File: rtl/change_return_timer.sv
// change_return_timer: inactivity / return-request timer with greedy change dispensing.
//
// Ports:
//   clk, reset_n           clock; synchronous active-low reset
//   i_input_coin           one-hot coin insertion pulse (restarts the inactivity timer)
//   i_item_ok              purchase accepted (restarts the inactivity timer)
//   i_trigger_return       user return request; it is a level signal
//   i_current_total        balance held by the upstream total register
//   i_coin_value           flattened ascending coin values, coin k at [k*TOTAL_BITS +: TOTAL_BITS]
//   disp (master)          o_return_coin / o_return_valid / i_disp_ready dispenser handshake
//   o_sub_value            amount debited this cycle; nonzero only on a dispenser handshake
//   o_busy                 high while the return delay runs or change is dispensed
//   o_timeout              one-cycle pulse when the inactivity timer expires
//
// Optional build macro RETURN_BURST_EN:
//   - When defined, each handshake may carry one of every denomination that still fits.
//   - When undefined, each handshake carries exactly one coin.
module change_return_timer #(
  parameter int NUM_COINS    = 3,
  parameter int TOTAL_BITS   = 31,
  parameter int WAIT_CYCLES  = 10,
  parameter int RETURN_DELAY = 3
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_COINS-1:0]            i_input_coin,
  input  logic                            i_item_ok,
  input  logic                            i_trigger_return,
  input  logic [TOTAL_BITS-1:0]           i_current_total,
  input  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value,
  change_return_timer_if.master           disp,
  output logic [TOTAL_BITS-1:0]           o_sub_value,
  output logic                            o_busy,
  output logic                            o_timeout
);

  // The legal parameter ranges fit in these widths: WAIT_CYCLES < 2^16 and RETURN_DELAY < 2^8.
  localparam int WAIT_W = 16;
  localparam int DLY_W  = 8;

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(RETURN_DELAY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DELAY,
    ST_RETURN
  } state_t;

  state_t                state_q,   state_d;
  logic [WAIT_W-1:0]     wait_q,    wait_d;
  logic [DLY_W-1:0]      dly_q,     dly_d;
  logic [TOTAL_BITS-1:0] rem_q,     rem_d;
  logic                  timeout_q, timeout_d;

  logic [TOTAL_BITS-1:0] coin_val [NUM_COINS];
  logic [NUM_COINS-1:0]  sel_coin;
  logic [TOTAL_BITS-1:0] sel_sum;
  logic                  coin_fits;
  logic                  activity;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_unpack
    assign coin_val[g] = i_coin_value[g*TOTAL_BITS +: TOTAL_BITS];
  end

  // Coin selection against the latched remaining amount.
  // Coin values are ascending, so coin 0 fitting is the same as "anything fits".
`ifdef RETURN_BURST_EN
  // Scan from the largest coin down. Take each coin that still fits the unclaimed
  // remainder. rem_q - sel_sum cannot underflow because sel_sum never exceeds rem_q.
  always_comb begin
    sel_coin = '0;
    sel_sum  = '0;
    for (int k = NUM_COINS - 1; k >= 0; k--) begin
      if (coin_val[k] <= rem_q - sel_sum) begin
        sel_coin[k] = 1'b1;
        sel_sum     = sel_sum + coin_val[k];
      end
    end
  end
`else
  // The largest fitting coin wins, so a later (higher) index overrides an earlier one.
  always_comb begin
    sel_coin = '0;
    sel_sum  = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (coin_val[k] <= rem_q) begin
        sel_coin    = '0;
        sel_coin[k] = 1'b1;
        sel_sum     = coin_val[k];
      end
    end
  end
`endif

  assign coin_fits = |sel_coin;
  assign activity  = (|i_input_coin) | i_item_ok;

  // State register and counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= WAIT_INIT;
      dly_q     <= '0;
      rem_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      dly_q     <= dly_d;
      rem_q     <= rem_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, counter updates and outputs.
  always_comb begin
    state_d             = state_q;
    wait_d              = wait_q;
    dly_d               = dly_q;
    rem_d               = rem_q;
    timeout_d           = 1'b0;
    o_busy              = 1'b0;
    disp.o_return_valid = 1'b0;
    disp.o_return_coin  = '0;
    o_sub_value         = '0;

    case (state_q)
      ST_IDLE: begin
        wait_d = WAIT_INIT;
        if (i_trigger_return) begin
          state_d = ST_DELAY;
          dly_d   = DLY_W'(1);
        end else if (i_current_total != '0) begin
          state_d = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (i_trigger_return) begin
          state_d = ST_DELAY;
          dly_d   = DLY_W'(1);
        end else if (i_current_total == '0) begin
          state_d = ST_IDLE;
          wait_d  = WAIT_INIT;
        end else if (activity) begin
          wait_d = WAIT_INIT;
        end else if (wait_q == WAIT_W'(1)) begin
          // Expiry: the pulse is registered, so it appears in the first RETURN cycle.
          state_d   = ST_RETURN;
          timeout_d = 1'b1;
          rem_d     = i_current_total;
          wait_d    = WAIT_INIT;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      ST_DELAY: begin
        o_busy = 1'b1;
        if (activity) begin
          wait_d = WAIT_INIT;
        end
        if (!i_trigger_return) begin
          // The request was withdrawn. Resume the inactivity timer from full.
          state_d = ST_COUNT;
          wait_d  = WAIT_INIT;
          dly_d   = '0;
        end else if (dly_q == DLY_LAST) begin
          state_d = ST_RETURN;
          rem_d   = i_current_total;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      ST_RETURN: begin
        o_busy              = 1'b1;
        wait_d              = WAIT_INIT;
        disp.o_return_valid = coin_fits;
        disp.o_return_coin  = sel_coin;
        if (!coin_fits) begin
          // Any residual below the smallest coin stays with the upstream total.
          state_d = ST_IDLE;
        end else if (disp.i_disp_ready) begin
          rem_d       = rem_q - sel_sum;
          o_sub_value = sel_sum;
        end
      end

      default: begin
        state_d = ST_IDLE;
        wait_d  = WAIT_INIT;
        dly_d   = '0;
      end
    endcase
  end

  assign o_timeout = timeout_q;

endmodule
